// File: rtl/dmem_bridge_if.sv
// External data-memory bus between the bridge (master) and the memory (slave).
interface dmem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: turns a single-cycle load/store strobe into a
// req/ack bus transfer, stalling the pipeline until the transfer completes.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ABORT_DATA     = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wd,
  input  logic                 dmem_we,
  input  logic                 dmem_re,
  output logic [31:0]          dmem_rd,
  output logic                 stallM,
  dmem_bridge_if.master        bus,
  output logic                 misalign_err,
  output logic                 timeout_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                misalign_q, misalign_d;
  logic                timeout_q, timeout_d;

  logic strobe_c;
  logic access_c;
  logic misalign_c;
  logic ack_c;
  logic expire_c;

  // Classify the MEM-stage request and the REQ-state completion events.
  always_comb begin
    strobe_c   = dmem_we | dmem_re;
    access_c   = strobe_c & (dmem_addr[1:0] == 2'b00);
    misalign_c = strobe_c & (dmem_addr[1:0] != 2'b00);
    ack_c      = (state_q == S_REQ) & bus.bus_ack;
    // Ack has priority, so expiry is only raised on a cycle without ack.
    expire_c   = (state_q == S_REQ) & ~bus.bus_ack & (wait_q == WAIT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE never accepts a new access and always lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (access_c) state_d = S_REQ;
      S_REQ:   if (ack_c || expire_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: stall covers the accepting IDLE cycle and all of REQ.
  always_comb begin
    stallM        = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = addr_q;
    bus.bus_wdata = wd_q;
    dmem_rd       = '0;
    misalign_err  = misalign_q;
    timeout_err   = timeout_q;
    unique case (state_q)
      S_IDLE: stallM = access_c;
      S_REQ: begin
        stallM      = 1'b1;
        bus.bus_req = 1'b1;
        bus.bus_we  = we_q;
      end
      S_DONE:  dmem_rd = we_q ? '0 : rdata_q;
      default: ;
    endcase
  end

  // Datapath next-state: capture, wait counting, read-data latch, sticky errors.
  always_comb begin
    addr_d     = addr_q;
    wd_d       = wd_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    if (state_q == S_IDLE) begin
      if (access_c) begin
        addr_d = dmem_addr;
        wd_d   = dmem_wd;
        we_d   = dmem_we;
        wait_d = '0;
      end
      if (misalign_c) misalign_d = 1'b1;
    end else if (state_q == S_REQ) begin
      if (ack_c) begin
        if (!we_q) rdata_d = bus.bus_rdata;
      end else begin
        if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
        if (expire_c) begin
          if (!we_q) rdata_d = ABORT_DATA;
          timeout_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      wait_q     <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      wait_q     <= wait_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus pushes expected transfers,
// a negedge monitor checks bus phases and the DONE response.
module tb_dmem_bridge;

  localparam int unsigned TMO = 5;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    logic        terr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rd;
  logic        stallM;
  logic        misalign_err;
  logic        timeout_err;

  dmem_bridge_if mif();

  dmem_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .ABORT_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_addr   (dmem_addr),
    .dmem_wd     (dmem_wd),
    .dmem_we     (dmem_we),
    .dmem_re     (dmem_re),
    .dmem_rd     (dmem_rd),
    .stallM      (stallM),
    .bus         (mif),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err)
  );

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   epoch   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every REQ cycle against the head entry, pops it at DONE.
  int   mon_epoch = 0;
  bit   prev_req  = 1'b0;
  int   stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (epoch != mon_epoch) begin
      mon_epoch = epoch;
      prev_req  = 1'b0;
      stall_cnt = 0;
    end
    if (rst_n) begin
      if (mif.bus_req) begin
        if (sb.size() == 0) begin
          chk("req_without_expect", 32'(mif.bus_req), 32'd0);
        end else begin
          e = sb[0];
          chk("bus_addr", mif.bus_addr, e.addr);
          chk("bus_we", 32'(mif.bus_we), 32'(e.we));
          chk("bus_wdata", mif.bus_wdata, e.wd);
          chk("rd_zero_in_req", dmem_rd, 32'd0);
        end
      end else if (prev_req) begin
        if (sb.size() == 0) begin
          chk("done_without_expect", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_rd", dmem_rd, e.rd);
          chk("done_stall_low", 32'(stallM), 32'd0);
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          chk("done_timeout_err", 32'(timeout_err), 32'(e.terr));
        end
        stall_cnt = 0;
      end
      if (stallM) stall_cnt++;
      prev_req = mif.bus_req;
    end
  end

  // One aligned access; ack_n = REQ cycle carrying ack (0 = never ack).
  task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                        input logic we, input logic re, input int ack_n,
                        input logic [31:0] rdata, input logic [31:0] exp_rd,
                        input logic exp_terr, input bit hold, input bit stray);
    exp_t e;
    int   n_req;
    n_req   = (ack_n > 0) ? ack_n : int'(TMO);
    e.we    = we;
    e.addr  = addr;
    e.wd    = wd;
    e.rd    = exp_rd;
    e.stall = n_req + 1;
    e.terr  = exp_terr;
    sb.push_back(e);
    dmem_addr = addr;
    dmem_wd   = wd;
    dmem_we   = we;
    dmem_re   = re;
    @(posedge clk); #1;
    for (int k = 1; k <= n_req; k++) begin
      mif.bus_ack   = (k == ack_n);
      mif.bus_rdata = (k == ack_n) ? rdata : 32'h5A5A_5A5A;
      @(posedge clk); #1;
    end
    mif.bus_ack   = stray;
    mif.bus_rdata = stray ? 32'hFFFF_0000 : 32'h0;
    @(posedge clk); #1;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0;
    if (!hold) begin
      dmem_we = 1'b0;
      dmem_re = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    dmem_addr     = 32'h0;
    dmem_wd       = 32'h0;
    dmem_we       = 1'b0;
    dmem_re       = 1'b0;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0;
    #1;
    chk("rst_bus_req", 32'(mif.bus_req), 32'd0);
    chk("rst_bus_we", 32'(mif.bus_we), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_rd", dmem_rd, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load, ack in first REQ cycle; accepted on first edge after reset.
    access(32'h100, 32'h0, 1'b0, 1'b1, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    // Store, ack in 5th REQ cycle which is also the expiry cycle: ack wins.
    access(32'h200, 32'hCAFE_F00D, 1'b1, 1'b0, 5, 32'h7777_7777, 32'h0, 1'b0, 1'b0, 1'b0);
    // Both strobes high: performed as a write.
    access(32'h300, 32'h1111_2222, 1'b1, 1'b1, 2, 32'h5555_5555, 32'h0, 1'b0, 1'b0, 1'b0);
    access(32'h104, 32'h0, 1'b0, 1'b1, 3, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0);

    // Misaligned load: no stall, no request, error on next edge.
    dmem_addr = 32'h102;
    dmem_re   = 1'b1;
    @(negedge clk);
    chk("mis_stall", 32'(stallM), 32'd0);
    chk("mis_req", 32'(mif.bus_req), 32'd0);
    chk("mis_rd", dmem_rd, 32'd0);
    chk("mis_err_before_edge", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    chk("mis_err_set", 32'(misalign_err), 32'd1);
    chk("mis_req_after", 32'(mif.bus_req), 32'd0);
    dmem_re = 1'b0;
    @(posedge clk); #1;

    // Load never acked: aborts after TMO REQ cycles with ABORT_DATA.
    access(32'h400, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    access(32'h108, 32'h0, 1'b0, 1'b1, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);

    // Reset in the 2nd REQ cycle abandons the transfer immediately.
    begin
      exp_t e;
      e.we = 1'b0; e.addr = 32'h100; e.wd = 32'h0; e.rd = 32'h0; e.stall = 0; e.terr = 1'b1;
      sb.push_back(e);
    end
    dmem_addr = 32'h100;
    dmem_wd   = 32'h0;
    dmem_re   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem_re = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_req", 32'(mif.bus_req), 32'd0);
    chk("midrst_we", 32'(mif.bus_we), 32'd0);
    chk("midrst_stall", 32'(stallM), 32'd0);
    chk("midrst_rd", dmem_rd, 32'd0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    chk("midrst_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    epoch++;
    @(posedge clk); #1;
    access(32'h100, 32'h0, 1'b0, 1'b1, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Back-to-back loads held across DONE, with a stray ack in DONE.
    access(32'h10C, 32'h0, 1'b0, 1'b1, 2, 32'h0102_0304, 32'h0102_0304, 1'b0, 1'b1, 1'b1);
    access(32'h10C, 32'h0, 1'b0, 1'b1, 1, 32'h0506_0708, 32'h0506_0708, 1'b0, 1'b0, 1'b0);
    chk("timeout_clear_after_rst", 32'(timeout_err), 32'd0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
